// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-side memory alignment logic.
package riscv_mem_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic {
      IDLE      = 1'b0,
      RMW_WRITE = 1'b1
   } dmem_state_t;

   // Map the raw 2-bit size field onto the enum; the unused code 2'b11 acts as a word.
   function automatic mem_size_t decode_size(input logic [1:0] raw);
      mem_size_t s;
      case (raw)
         2'b00:   s = MEM_BYTE;
         2'b01:   s = MEM_HALF;
         default: s = MEM_WORD;
      endcase
      return s;
   endfunction

   // An access is misaligned when any address bit below its natural size is set.
   function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
      logic r;
      case (size)
         MEM_BYTE: r = 1'b0;
         MEM_HALF: r = offset[0];
         default:  r = (offset != 2'b00);
      endcase
      return r;
   endfunction

   // Clear the address bits below the access size so lane selection is always aligned.
   function automatic logic [1:0] force_align(input mem_size_t size, input logic [1:0] offset);
      logic [1:0] r;
      case (size)
         MEM_BYTE: r = offset;
         MEM_HALF: r = {offset[1], 1'b0};
         default:  r = 2'b00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/riscv_load_extract.sv
// Combinational lane extraction with sign/zero extension for sub-word loads.
module riscv_load_extract
   import riscv_mem_pkg::*;
(
   input  logic [XLEN-1:0] data,
   input  logic [1:0]      offset,
   input  mem_size_t       size,
   input  logic            zero_ext,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Select the addressed lane and extend it to a full word.
   always_comb begin
      byte_lane = data[7:0];
      half_lane = data[15:0];
      result    = data;
      case (offset)
         2'b00:   byte_lane = data[7:0];
         2'b01:   byte_lane = data[15:8];
         2'b10:   byte_lane = data[23:16];
         default: byte_lane = data[31:24];
      endcase
      half_lane = offset[1] ? data[31:16] : data[15:0];
      case (size)
         MEM_BYTE: result = {{24{byte_lane[7] & ~zero_ext}}, byte_lane};
         MEM_HALF: result = {{16{half_lane[15] & ~zero_ext}}, half_lane};
         default:  result = data;
      endcase
   end

endmodule

// File: rtl/riscv_dmem_align.sv
// Byte/half/word adapter between the processor data port and a word-only memory.
// Sub-word stores are a two-cycle read-modify-write; loads are extracted one cycle later.
module riscv_dmem_align
   import riscv_mem_pkg::*;
#(
   parameter bit CHECK_ALIGNMENT = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] cpu_addr,
   input  logic            cpu_read,
   input  logic            cpu_write,
   input  logic [1:0]      cpu_size,
   input  logic            cpu_unsigned,
   input  logic [XLEN-1:0] cpu_wdata,
   output logic [XLEN-1:0] cpu_rdata,
   output logic            stall,
   output logic            misaligned,
   output logic [XLEN-1:0] mem_addr,
   output logic            mem_write,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   dmem_state_t state;

   // Store capture for the write half of the read-modify-write.
   logic [XLEN-3:0] cap_waddr;
   logic [1:0]      cap_off;
   mem_size_t       cap_size;
   logic [15:0]     cap_wdata;

   // Load controls, applied to the memory data returned one cycle later.
   logic [1:0]      ld_off;
   mem_size_t       ld_size;
   logic            ld_unsigned;

   mem_size_t       req_size;
   logic [1:0]      req_off;
   logic            req_mis;
   logic            sub_store;

   // Replace the addressed byte or halfword of a memory word with new store data.
   function automatic logic [XLEN-1:0] merge_lanes(input logic [XLEN-1:0] old,
                                                   input logic [15:0] data,
                                                   input logic [1:0] off,
                                                   input mem_size_t size);
      logic [XLEN-1:0] w;
      w = old;
      if (size == MEM_BYTE) begin
         case (off)
            2'b00:   w[7:0]   = data[7:0];
            2'b01:   w[15:8]  = data[7:0];
            2'b10:   w[23:16] = data[7:0];
            default: w[31:24] = data[7:0];
         endcase
      end else if (off[1]) begin
         w[31:16] = data;
      end else begin
         w[15:0] = data;
      end
      return w;
   endfunction

   // Decode the incoming request: normalised size, aligned offset, error flag.
   always_comb begin
      req_size  = decode_size(cpu_size);
      req_off   = force_align(req_size, cpu_addr[1:0]);
      req_mis   = CHECK_ALIGNMENT && (cpu_read || cpu_write)
                  && is_misaligned(req_size, cpu_addr[1:0]);
      sub_store = cpu_write && !req_mis && (req_size != MEM_WORD);
   end

   // State register plus store/load capture registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cap_waddr   <= '0;
         cap_off     <= 2'b00;
         cap_size    <= MEM_BYTE;
         cap_wdata   <= 16'h0000;
         ld_off      <= 2'b00;
         ld_size     <= MEM_BYTE;
         ld_unsigned <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sub_store) begin
                  state     <= RMW_WRITE;
                  cap_waddr <= cpu_addr[XLEN-1:2];
                  cap_off   <= req_off;
                  cap_size  <= req_size;
                  cap_wdata <= cpu_wdata[15:0];
               end else if (cpu_read && !req_mis) begin
                  ld_off      <= req_off;
                  ld_size     <= req_size;
                  ld_unsigned <= cpu_unsigned;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory-side outputs; reset blocks any write in the same cycle.
   always_comb begin
      mem_addr   = {cpu_addr[XLEN-1:2], 2'b00};
      mem_write  = 1'b0;
      mem_wdata  = cpu_wdata;
      stall      = 1'b0;
      misaligned = 1'b0;
      case (state)
         IDLE: begin
            misaligned = req_mis;
            if (sub_store) begin
               stall = 1'b1;
            end else if (cpu_write && !req_mis) begin
               mem_write = !rst;
            end
         end
         default: begin
            mem_addr  = {cap_waddr, 2'b00};
            mem_write = !rst;
            mem_wdata = merge_lanes(mem_rdata, cap_wdata, cap_off, cap_size);
         end
      endcase
   end

   riscv_load_extract u_extract (
      .data     (mem_rdata),
      .offset   (ld_off),
      .size     (ld_size),
      .zero_ext (ld_unsigned),
      .result   (cpu_rdata)
   );

endmodule

// File: doc/riscv_dmem_align.md
Name: riscv_dmem_align

Overview:
Sits between the processor's data-memory port and the word-only data memory, which has synchronous reads and full-word writes. It converts byte and halfword accesses into word accesses. Loads get lane extraction plus sign or zero extension. Sub-word stores become a 2-cycle read-modify-write (RMW) that stalls the processor for one cycle. Misaligned accesses are flagged and never reach memory.

Parameters:
CHECK_ALIGNMENT, 1, 1 = detect misaligned half/word accesses and suppress them; 0 = ignore the offending low address bits (force alignment), never flag.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_addr  in  32  byte address from the processor
cpu_read  in  1  load request
cpu_write  in  1  store request (cpu_read and cpu_write are never both high)
cpu_size  in  2  access size: 00 byte, 01 half, 10 word (11 treated as word)
cpu_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
cpu_wdata  in  32  store data, right-justified
cpu_rdata  out  32  extracted/extended load data
stall  out  1  processor must hold its current access this cycle
misaligned  out  1  one-cycle error pulse
mem_addr  out  32  word address to memory, bits [1:0] always 0
mem_write  out  1  memory write enable
mem_wdata  out  32  full word to memory
mem_rdata  in  32  registered memory read data, valid the cycle after the address

Behaviour:
- States: IDLE, RMW_WRITE. Reset → IDLE, all capture registers 0.
- Outputs in IDLE with no request: stall=0, misaligned=0, mem_write=0, mem_addr={cpu_addr[31:2],2'b00}.
- Alignment: half misaligned if addr[0]=1; word misaligned if addr[1:0]≠0; byte never misaligned.
- Misaligned access (CHECK_ALIGNMENT=1), IDLE:
  - misaligned=1 (combinational, same cycle), mem_write=0, stall=0.
  - Load capture registers are not updated.
- IDLE, aligned word store: mem_write=1, mem_wdata=cpu_wdata, stall=0. Single cycle.
- IDLE, aligned byte/half store (cycle 1):
  - mem_write=0, stall=1, mem_addr=word address.
  - Capture word address, addr[1:0], size and cpu_wdata. Next state RMW_WRITE.
- RMW_WRITE (cycle 2):
  - mem_addr=captured word address, mem_write=1, stall=0.
  - mem_wdata = mem_rdata with the target lane(s) replaced: byte lane k gets wdata[7:0] at bits 8k+7:8k; half at offset 2 replaces [31:16], at offset 0 replaces [15:0].
  - cpu_* inputs are ignored in this state (the processor is re-presenting the same store). Next state IDLE.
- Loads (IDLE, aligned, cpu_read=1):
  - mem_addr=word address, no stall.
  - Register addr[1:0], size and cpu_unsigned.
  - In the next cycle, cpu_rdata = extract(mem_rdata, registered controls); latency 1, matching the memory.
- Extraction:
  - byte: lane addr[1:0], extended from bit 7.
  - half: lane addr[1], extended from bit 15.
  - word: unchanged.
- cpu_rdata when no load was issued the previous cycle: extract using the last captured controls. Value is don't-care for the processor, but must be deterministic (no X after reset).
- Back-to-back: a load or store presented in the cycle after RMW_WRITE is accepted normally. A load in cycle 2 of an RMW is not possible because the processor is holding the store.
- Reset asserted in RMW_WRITE: mem_write must be 0 in that cycle (reset has priority), state → IDLE, no partial write.
- CHECK_ALIGNMENT=0: low bits below the access size are masked to 0 before lane selection. misaligned stays 0.

Decomposition:
- Package riscv_mem_pkg:
  - mem_size_t enum (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10).
  - dmem_state_t enum (IDLE, RMW_WRITE).
  - Function is_misaligned(size, offset).
- Sub-module riscv_load_extract: purely combinational (mem_rdata, offset, size, unsigned → 32-bit result). It is shared with any future instruction-side halfword fetch.
- Store merge logic and the FSM stay in the top module.

Test Plan:
- Preload word 0x00800004 = 0xAABBCCDD. sb 0x11 @0x00800005 →
  - cycle 1: stall=1, mem_write=0.
  - cycle 2: mem_write=1, mem_wdata=0xAABB11DD, mem_addr=0x00800004.
  - Memory then reads back 0xAABB11DD.
- Same word. lh @0x00800006 signed → cpu_rdata=0xFFFFAABB one cycle later. lhu same address → 0x0000AABB. lbu @0x00800007 → 0x000000AA. lb @0x00800004 → 0xFFFFFFDD.
- sw 0x12345678 @0x00800002 (CHECK_ALIGNMENT=1) →
  - misaligned=1 for exactly 1 cycle, mem_write never 1, stall=0, memory unchanged.
  - Repeat with CHECK_ALIGNMENT=0 → word written at 0x00800000, misaligned=0.
- sh 0xBEEF @0x00800004 immediately followed by lw @0x00800004 →
  - write data 0xAABBBEEF.
  - Load accepted in the cycle after RMW_WRITE, returns 0xAABBBEEF.
- sb issued, rst=1 in the RMW_WRITE cycle → mem_write=0 that cycle, state IDLE, memory word unchanged (0xAABBCCDD).
- Word sw 0xCAFEF00D @0x00800008 → single cycle, stall never asserted, mem_wdata=0xCAFEF00D.
